// File: rtl/cal_date_counter_pkg.sv
// Calendar constants shared by the date counter and its helpers.
// Field widths, limits, reset date and ADJ_SEL encodings.
package cal_date_counter_pkg;

  localparam int YEAR_W  = 7;
  localparam int MONTH_W = 4;
  localparam int DAY_W   = 5;

  localparam logic [6:0] YEAR_MAX  = 7'd99;
  localparam logic [3:0] MONTH_MAX = 4'd12;

  localparam logic [6:0] RST_YEAR  = 7'd0;
  localparam logic [3:0] RST_MONTH = 4'd1;
  localparam logic [4:0] RST_DAY   = 5'd1;

  localparam logic [1:0] SEL_DAY   = 2'b00;
  localparam logic [1:0] SEL_MONTH = 2'b01;
  localparam logic [1:0] SEL_YEAR  = 2'b10;
  localparam logic [1:0] SEL_NONE  = 2'b11;

  // Years 00..99 map to 2000..2099, where every 4th year is leap.
  function automatic logic is_leap(input logic [6:0] y);
    return (y[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/cal_month_days.sv
// Combinational month length: (month, year) -> 28/29/30/31.
// Ports: month[3:0], year[6:0] in; max_day[4:0] out.
module cal_month_days
  import cal_date_counter_pkg::*;
(
  input  logic [3:0] month,
  input  logic [6:0] year,
  output logic [4:0] max_day
);

  // Out-of-range months report 31; callers range-check month.
  always_comb begin
    max_day = 5'd31;
    case (month)
      4'd4, 4'd6,
      4'd9, 4'd11: max_day = 5'd30;
      4'd2:        max_day = is_leap(year)
                             ? 5'd29 : 5'd28;
      default:     max_day = 5'd31;
    endcase
  end

endmodule

// File: rtl/cal_date_counter.sv
// Year/month/day counter with day-tick, load and field adjust.
// Ports: CLK, RESET, DAY_TICK, LOAD, LD_*, ADJ, ADJ_SEL in;
//        YEAR, MONTH, DAY, YEAR_WRAP, LOAD_ERR out (registered).
module cal_date_counter
  import cal_date_counter_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DAY_TICK,
  input  logic       LOAD,
  input  logic [6:0] LD_YEAR,
  input  logic [3:0] LD_MONTH,
  input  logic [4:0] LD_DAY,
  input  logic       ADJ,
  input  logic [1:0] ADJ_SEL,
  output logic [6:0] YEAR,
  output logic [3:0] MONTH,
  output logic [4:0] DAY,
  output logic       YEAR_WRAP,
  output logic       LOAD_ERR
);

  logic [4:0] cur_max;
  logic [4:0] alt_max;
  logic [6:0] alt_year;
  logic [3:0] alt_month;
  logic [6:0] inc_year;
  logic [3:0] inc_month;
  logic       load_ok;

  logic [6:0] n_year;
  logic [3:0] n_month;
  logic [4:0] n_day;
  logic       n_wrap;
  logic       n_err;

  assign inc_year  = (YEAR == YEAR_MAX)
                     ? 7'd0 : YEAR + 7'd1;
  assign inc_month = (MONTH == MONTH_MAX)
                     ? 4'd1 : MONTH + 4'd1;

  // Second length lookup is shared: it checks LD_* on a load,
  // and gives the clamp limit for a month or year adjust.
  always_comb begin
    alt_year  = YEAR;
    alt_month = MONTH;
    if (LOAD) begin
      alt_year  = LD_YEAR;
      alt_month = LD_MONTH;
    end else if (ADJ && ADJ_SEL == SEL_MONTH) begin
      alt_month = inc_month;
    end else if (ADJ && ADJ_SEL == SEL_YEAR) begin
      alt_year = inc_year;
    end
  end

  cal_month_days u_cur (
    .month   (MONTH),
    .year    (YEAR),
    .max_day (cur_max)
  );

  cal_month_days u_alt (
    .month   (alt_month),
    .year    (alt_year),
    .max_day (alt_max)
  );

  assign load_ok = (LD_YEAR <= YEAR_MAX)
                && (LD_MONTH != 4'd0)
                && (LD_MONTH <= MONTH_MAX)
                && (LD_DAY != 5'd0)
                && (LD_DAY <= alt_max);

  always_comb begin
    n_year  = YEAR;
    n_month = MONTH;
    n_day   = DAY;
    n_wrap  = 1'b0;
    n_err   = 1'b0;
    if (LOAD) begin
      if (load_ok) begin
        n_year  = LD_YEAR;
        n_month = LD_MONTH;
        n_day   = LD_DAY;
      end else begin
        n_err = 1'b1;
      end
    end else if (ADJ) begin
      case (ADJ_SEL)
        SEL_DAY: begin
          n_day = (DAY >= cur_max)
                  ? 5'd1 : DAY + 5'd1;
        end
        SEL_MONTH: begin
          n_month = inc_month;
          if (DAY > alt_max) n_day = alt_max;
        end
        SEL_YEAR: begin
          n_year = inc_year;
          if (DAY > alt_max) n_day = alt_max;
        end
        default: ;
      endcase
    end else if (DAY_TICK) begin
      if (DAY < cur_max) begin
        n_day = DAY + 5'd1;
      end else begin
        n_day   = 5'd1;
        n_month = inc_month;
        if (MONTH == MONTH_MAX) begin
          n_year = inc_year;
          n_wrap = (YEAR == YEAR_MAX);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      YEAR      <= RST_YEAR;
      MONTH     <= RST_MONTH;
      DAY       <= RST_DAY;
      YEAR_WRAP <= 1'b0;
      LOAD_ERR  <= 1'b0;
    end else begin
      YEAR      <= n_year;
      MONTH     <= n_month;
      DAY       <= n_day;
      YEAR_WRAP <= n_wrap;
      LOAD_ERR  <= n_err;
    end
  end

endmodule

// File: doc/cal_date_counter.md
# cal_date_counter

Sequential date counter that keeps year (00–99, i.e. 2000–2099), month and day for the calendar path, advancing once per day-tick from the time-of-day counter. Its 7-bit binary YEAR output directly feeds the year two-digit BCD splitter (binary 0–99 to tens/units digits) that drives the year display. It also supports parallel load and per-field user adjustment, with leap-year-correct month lengths.

## Interface
- No parameters; all limits are fixed constants (see Structure).
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- DAY_TICK  in  1  one-cycle pulse: advance date by one day
- LOAD  in  1  one-cycle pulse: load LD_YEAR/LD_MONTH/LD_DAY
- LD_YEAR  in  7  load value, binary 0–99
- LD_MONTH  in  4  load value, 1–12
- LD_DAY  in  5  load value, 1–31
- ADJ  in  1  one-cycle pulse: increment field selected by ADJ_SEL
- ADJ_SEL  in  2  00=day, 01=month, 10=year, 11=no-op
- YEAR  out  7  current year, binary 0–99 (to year BCD splitter)
- MONTH  out  4  current month, binary 1–12
- DAY  out  5  current day, binary 1–31
- YEAR_WRAP  out  1  one-cycle pulse on 99→00 rollover via DAY_TICK
- LOAD_ERR  out  1  one-cycle pulse when a LOAD is rejected

## Operation
- Reset state: YEAR=0, MONTH=1, DAY=1, YEAR_WRAP=0, LOAD_ERR=0 (2000-01-01).
- Month length: 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; February 29 if YEAR[1:0]==0 else 28 (00 is leap).
- Priority per cycle: LOAD > ADJ > DAY_TICK; lower-priority events in the same cycle are dropped, not queued.
- DAY_TICK: DAY<max → DAY+1. DAY==max → DAY=1, MONTH+1; MONTH==12 → MONTH=1, YEAR+1; YEAR==99 → YEAR=0 and YEAR_WRAP=1.
- LOAD: accepted only if LD_YEAR≤99, 1≤LD_MONTH≤12, 1≤LD_DAY≤max(LD_MONTH, LD_YEAR). Accepted: all three fields update atomically. Rejected: state unchanged, LOAD_ERR=1.
- ADJ day: DAY wraps max→1, no carry into month.
- ADJ month: MONTH wraps 12→1, no carry into year; DAY then clamped to new month's max.
- ADJ year: YEAR wraps 99→0, no YEAR_WRAP; DAY clamped (29 Feb → 28 Feb in non-leap year).
- ADJ_SEL=11: no effect.
- Invariant: outputs always form a valid date; no illegal state reachable.

## Timing
- All outputs registered; a pulse at edge N is visible after edge N (latency 1 cycle).
- Full day/month/year cascade completes in a single cycle; no intermediate states visible.
- YEAR_WRAP and LOAD_ERR high exactly one cycle, low otherwise.
- RESET asserted mid-operation forces the reset state immediately, independent of CLK; pulses coinciding with reset deassertion edge are ignored only if RESET still high at that edge.
- Back-to-back DAY_TICK on consecutive cycles each advance one day.

## Structure
- Shared calendar package: field widths (YEAR 7, MONTH 4, DAY 5), YEAR_MAX=99, MONTH_MAX=12, reset date constants, ADJ_SEL encodings.
- One sub-module: cal_month_days — combinational (month, year) → max day (28/29/30/31); instantiated twice (current date and LOAD validation).
- Remaining logic: one registered state block plus next-state combinational logic in cal_date_counter.

## Test plan
- Reset, then 31 DAY_TICKs → 2000-02-01 (YEAR=0, MONTH=2, DAY=1); YEAR_WRAP stays 0.
- LOAD 04-02-28, DAY_TICK → 04-02-29; LOAD 03-02-28, DAY_TICK → 03-03-01.
- LOAD 99-12-31, DAY_TICK → 00-01-01 with YEAR_WRAP=1 for exactly one cycle; YEAR feeds splitter as 0.
- LOAD 05-02-29 → LOAD_ERR=1 one cycle, state unchanged; LOAD 100-01-01 and month 13 → both rejected.
- LOAD 04-02-29, ADJ year → 05-02-28; LOAD 01-01-31, ADJ month → 01-02-28; ADJ day at 01-04-30 → 01-04-01.
- LOAD and DAY_TICK same cycle → loaded value, no advance; RESET asserted between edges → outputs 00-01-01 immediately.
